// File: rtl/rom_load_pkg.sv
// Shared types, widths and helpers for the ROM download controller.
// State encoding, region index and region-relative address arithmetic.
package rom_load_pkg;

    localparam int ADDR_W  = 25;
    localparam int RADDR_W = 16;

    typedef enum logic [2:0] {
        BOOT,
        LOAD,
        CHECK,
        ERROR,
        HOLD,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        REG_CPU,
        REG_SPR,
        REG_TILE,
        REG_PROM
    } region_t;

    function automatic logic [RADDR_W-1:0] rel_offset(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] base
    );
        return RADDR_W'(addr - base);
    endfunction

    // A region is legal when its bounds are ordered and it spans at most 64 KiB.
    function automatic bit region_fits(
        input logic [ADDR_W-1:0] lo,
        input logic [ADDR_W-1:0] hi
    );
        return (hi >= lo) && ((hi - lo) <= ADDR_W'(32'h0001_0000));
    endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Combinational region lookup: maps an image byte address to its ROM region,
// the region-relative offset, and whether it lies inside the image at all.
module rom_region_decode
    import rom_load_pkg::*;
#(
    parameter logic [ADDR_W-1:0] REG1_BASE  = 25'h0C000,
    parameter logic [ADDR_W-1:0] REG2_BASE  = 25'h14000,
    parameter logic [ADDR_W-1:0] REG3_BASE  = 25'h1C000,
    parameter logic [ADDR_W-1:0] TOTAL_SIZE = 25'h1C220
) (
    input  logic [ADDR_W-1:0]  addr_i,
    output region_t            region_o,
    output logic               in_range_o,
    output logic [RADDR_W-1:0] rel_addr_o
);

    logic [ADDR_W-1:0] base;

    always_comb begin
        region_o   = REG_CPU;
        base       = '0;
        in_range_o = 1'b1;
        if (addr_i < REG1_BASE) begin
            region_o = REG_CPU;
            base     = '0;
        end else if (addr_i < REG2_BASE) begin
            region_o = REG_SPR;
            base     = REG1_BASE;
        end else if (addr_i < REG3_BASE) begin
            region_o = REG_TILE;
            base     = REG2_BASE;
        end else if (addr_i < TOTAL_SIZE) begin
            region_o = REG_PROM;
            base     = REG3_BASE;
        end else begin
            region_o   = REG_PROM;
            base       = REG3_BASE;
            in_range_o = 1'b0;
        end
    end

    assign rel_addr_o = rel_offset(addr_i, base);

endmodule

// File: rtl/rom_load_ctrl.sv
// Steers the HPS ROM download into four ROM regions, validates the image and
// gates the game core reset. Optional running checksum: define ROM_CHECKSUM_EN.
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter logic [ADDR_W-1:0] REG1_BASE   = 25'h0C000,
    parameter logic [ADDR_W-1:0] REG2_BASE   = 25'h14000,
    parameter logic [ADDR_W-1:0] REG3_BASE   = 25'h1C000,
    parameter logic [ADDR_W-1:0] TOTAL_SIZE  = 25'h1C220,
    parameter int unsigned       HOLD_CYCLES = 4096
`ifdef ROM_CHECKSUM_EN
    ,
    parameter logic [15:0]       EXP_SUM     = 16'h0000
`endif
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               dl_active,
    input  logic               dl_wr,
    input  logic [ADDR_W-1:0]  dl_addr,
    input  logic [7:0]         dl_data,
    output logic [3:0]         rom_we,
    output logic [RADDR_W-1:0] rom_addr,
    output logic [7:0]         rom_data,
    output logic               core_reset,
    output logic               load_done,
    output logic               load_error,
    output logic [ADDR_W-1:0]  byte_count
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [15:0]        checksum
`endif
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    generate
        if (!region_fits({ADDR_W{1'b0}}, REG1_BASE) || !region_fits(REG1_BASE, REG2_BASE) ||
            !region_fits(REG2_BASE, REG3_BASE) || !region_fits(REG3_BASE, TOTAL_SIZE) ||
            (HOLD_CYCLES == 0)) begin : g_bad_params
            $error("rom_load_ctrl: region bases unordered, a region exceeds 64 KiB, or HOLD_CYCLES is 0");
        end
    endgenerate

    state_t             state_q, state_d;
    logic               dl_active_q;
    logic               oor_q, oor_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [3:0]         we_q, we_d;
    logic [RADDR_W-1:0] addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic               core_reset_q, core_reset_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [ADDR_W-1:0]  count_q, count_d;
    logic [15:0]        sum_q, sum_d;

    region_t            dec_region;
    logic               dec_in_range;
    logic [RADDR_W-1:0] dec_rel_addr;
    logic               dl_rise;
    logic               image_bad;

    rom_region_decode #(
        .REG1_BASE  (REG1_BASE),
        .REG2_BASE  (REG2_BASE),
        .REG3_BASE  (REG3_BASE),
        .TOTAL_SIZE (TOTAL_SIZE)
    ) u_decode (
        .addr_i     (dl_addr),
        .region_o   (dec_region),
        .in_range_o (dec_in_range),
        .rel_addr_o (dec_rel_addr)
    );

    assign dl_rise = dl_active & ~dl_active_q;

`ifdef ROM_CHECKSUM_EN
    assign image_bad = (count_q != TOTAL_SIZE) | oor_q | ((EXP_SUM != 16'h0000) && (sum_q != EXP_SUM));
    assign checksum  = sum_q;
`else
    assign image_bad = (count_q != TOTAL_SIZE) | oor_q;
`endif

    always_comb begin
        state_d = state_q;
        oor_d   = oor_q;
        hold_d  = hold_q;
        we_d    = '0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        error_d = error_q;
        count_d = count_q;
        sum_d   = sum_q;

        unique case (state_q)
            LOAD: begin
                // Writes are taken every cycle here, including the one where dl_active drops.
                if (dl_wr) begin
                    count_d = (count_q == '1) ? count_q : count_q + 1'b1;
                    addr_d  = dec_rel_addr;
                    data_d  = dl_data;
                    if (dec_in_range) begin
                        we_d[dec_region] = 1'b1;
                        sum_d            = sum_q + {8'h00, dl_data};
                    end else begin
                        oor_d = 1'b1;
                    end
                end
                if (!dl_active) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (image_bad) begin
                    state_d = ERROR;
                    error_d = 1'b1;
                end else begin
                    state_d = HOLD;
                    hold_d  = HOLD_W'(HOLD_CYCLES - 1);
                end
            end
            default: begin
                // BOOT, ERROR, HOLD and RUN all restart on a new download.
                if (dl_rise) begin
                    state_d = LOAD;
                    count_d = '0;
                    error_d = 1'b0;
                    done_d  = 1'b0;
                    oor_d   = 1'b0;
                    sum_d   = '0;
                end else if (state_q == HOLD) begin
                    if (hold_q == '0) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
            end
        endcase

        core_reset_d = (state_d != RUN);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= BOOT;
            dl_active_q  <= 1'b0;
            oor_q        <= 1'b0;
            hold_q       <= '0;
            we_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            count_q      <= '0;
            sum_q        <= '0;
        end else begin
            state_q      <= state_d;
            dl_active_q  <= dl_active;
            oor_q        <= oor_d;
            hold_q       <= hold_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
        end
    end

    assign rom_we     = we_q;
    assign rom_addr   = addr_q;
    assign rom_data   = data_q;
    assign core_reset = core_reset_q;
    assign load_done  = done_q;
    assign load_error = error_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Self-checking bench for rom_load_ctrl using a scaled-down image map so that
// several complete loads fit in a short run; HOLD_CYCLES keeps its default.
module tb_rom_load_ctrl;

    localparam logic [24:0] R1   = 25'h0C0;
    localparam logic [24:0] R2   = 25'h140;
    localparam logic [24:0] R3   = 25'h1C0;
    localparam logic [24:0] TOT  = 25'h1E2;
    localparam int          HOLD = 4096;

    typedef struct packed {
        logic [3:0]  we;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic [3:0]  rom_we;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        core_reset;
    logic        load_done;
    logic        load_error;
    logic [24:0] byte_count;
`ifdef ROM_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    int   cnt_we[4];
    int   total_we = 0;
    bit   spr_seen = 0;
    logic [15:0] spr_first = '0;

    always #5 clk = ~clk;

    rom_load_ctrl #(
        .REG1_BASE   (R1),
        .REG2_BASE   (R2),
        .REG3_BASE   (R3),
        .TOTAL_SIZE  (TOT),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk_sys    (clk),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .rom_we     (rom_we),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error),
        .byte_count (byte_count)
`ifdef ROM_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    // Reference region map, written directly from the image layout.
    function automatic exp_t model(input logic [24:0] a, input logic [7:0] d);
        exp_t e;
        e.data = d;
        if (a < R1) begin
            e.we = 4'b0001; e.addr = 16'(a);
        end else if (a < R2) begin
            e.we = 4'b0010; e.addr = 16'(a - R1);
        end else if (a < R3) begin
            e.we = 4'b0100; e.addr = 16'(a - R2);
        end else begin
            e.we = 4'b1000; e.addr = 16'(a - R3);
        end
        return e;
    endfunction

    // Every ROM write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        exp_t e;
        if (rom_we !== 4'b0000) begin
            total_we++;
            for (int r = 0; r < 4; r++) if (rom_we[r] === 1'b1) cnt_we[r]++;
            if (rom_we[1] === 1'b1 && !spr_seen) begin
                spr_seen  = 1;
                spr_first = rom_addr;
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_we got we=%b addr=%h data=%h required no write", rom_we, rom_addr, rom_data);
            end else begin
                e = sb.pop_front();
                if ({rom_we, rom_addr, rom_data} !== e) begin
                    failures++;
                    $display("FAIL rom_write got we=%b addr=%h data=%h required we=%b addr=%h data=%h",
                             rom_we, rom_addr, rom_data, e.we, e.addr, e.data);
                end
            end
        end
    end

    task automatic clear_stats();
        for (int r = 0; r < 4; r++) cnt_we[r] = 0;
        spr_seen = 0;
    endtask

    task automatic start_load();
        @(negedge clk);
        dl_active = 1'b1;
        @(negedge clk);
    endtask

    task automatic stream(input int n, input bit fall_on_last);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d       = 8'($urandom);
            dl_wr   = 1'b1;
            dl_addr = 25'(i);
            dl_data = d;
            if (fall_on_last && i == n - 1) dl_active = 1'b0;
            sb.push_back(model(25'(i), d));
            @(negedge clk);
        end
        dl_wr = 1'b0;
    endtask

    task automatic wait_run(input string name);
        for (int k = 0; k < HOLD + 200; k++) begin
            @(negedge clk);
            if (load_done === 1'b1) break;
        end
        checks++;
        if (load_done !== 1'b1 || core_reset !== 1'b0) begin
            failures++;
            $display("FAIL %s_run got done=%b core_reset=%b required done=1 core_reset=0", name, load_done, core_reset);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({rom_we, rom_addr, rom_data, core_reset, load_done, load_error, byte_count} !==
            {4'h0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0, 25'h0}) begin
            failures++;
            $display("FAIL reset_values got we=%b addr=%h data=%h rst=%b done=%b err=%b cnt=%h required 0/0/0/1/0/0/0",
                     rom_we, rom_addr, rom_data, core_reset, load_done, load_error, byte_count);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (core_reset !== 1'b1 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL boot_idle got rst=%b done=%b required rst=1 done=0", core_reset, load_done);
        end
        $display("test_reset done");
    endtask

    task automatic test_good_load();
        int k;
        int req[4] = '{int'(R1), int'(R2 - R1), int'(R3 - R2), int'(TOT - R3)};
        clear_stats();
        start_load();
        stream(int'(TOT), 0);
        dl_active = 1'b0;
        @(posedge clk);
        k = 0;
        for (int i = 0; i < HOLD + 100; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (core_reset !== 1'b1) break;
        end
        checks++;
        if (k != HOLD + 1 || core_reset !== 1'b0) begin
            failures++;
            $display("FAIL release_delay got %0d cycles (rst=%b) required %0d", k, core_reset, HOLD + 1);
        end
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (cnt_we[r] != req[r]) begin
                failures++;
                $display("FAIL region%0d_writes got %0d required %0d", r, cnt_we[r], req[r]);
            end
        end
        checks++;
        if (!spr_seen || spr_first !== 16'h0) begin
            failures++;
            $display("FAIL sprite_first_addr got %h seen=%0d required 0000", spr_first, spr_seen);
        end
        checks++;
        if (load_done !== 1'b1 || load_error !== 1'b0 || byte_count !== TOT || sb.size() != 0) begin
            failures++;
            $display("FAIL good_status got done=%b err=%b cnt=%h pending=%0d required 1/0/%h/0",
                     load_done, load_error, byte_count, sb.size(), TOT);
        end
        $display("test_good_load done release=%0d", k);
    endtask

    task automatic test_short_load();
        int  we0;
        bit  stayed;
        clear_stats();
        start_load();
        stream(int'(TOT) - 1, 0);
        dl_active = 1'b0;
        repeat (2) @(negedge clk);
        we0    = total_we;
        stayed = 1;
        repeat (HOLD + 200) begin
            @(negedge clk);
            if (core_reset !== 1'b1) stayed = 0;
        end
        checks++;
        if (!stayed) begin
            failures++;
            $display("FAIL short_core_reset got released required held");
        end
        checks++;
        if (load_error !== 1'b1 || load_done !== 1'b0 || byte_count !== TOT - 1 || total_we != we0) begin
            failures++;
            $display("FAIL short_status got err=%b done=%b cnt=%h extra_we=%0d required 1/0/%h/0",
                     load_error, load_done, byte_count, total_we - we0, TOT - 1);
        end
        $display("test_short_load done");
    endtask

    task automatic test_out_of_range();
        clear_stats();
        start_load();
        stream(int'(TOT), 0);
        dl_wr   = 1'b1;
        dl_addr = TOT;
        dl_data = 8'hA5;
        @(negedge clk);
        dl_wr     = 1'b0;
        dl_active = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (byte_count !== TOT + 1 || load_error !== 1'b1 || cnt_we[3] != int'(TOT - R3) || sb.size() != 0) begin
            failures++;
            $display("FAIL oor_status got cnt=%h err=%b prom_we=%0d pending=%0d required %h/1/%0d/0",
                     byte_count, load_error, cnt_we[3], sb.size(), TOT + 1, int'(TOT - R3));
        end
        $display("test_out_of_range done");
    endtask

    task automatic test_edge_timing();
        int we0;
        logic [24:0] cnt0;
        start_load();
        stream(int'(TOT), 1);
        wait_run("edge");
        checks++;
        if (byte_count !== TOT || load_error !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL edge_last_byte got cnt=%h err=%b pending=%0d required %h/0/0",
                     byte_count, load_error, sb.size(), TOT);
        end
        we0  = total_we;
        cnt0 = byte_count;
        for (int i = 0; i < 2; i++) begin
            dl_wr   = 1'b1;
            dl_addr = 25'(i);
            dl_data = 8'h5A;
            @(negedge clk);
        end
        dl_wr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (total_we != we0 || byte_count !== cnt0) begin
            failures++;
            $display("FAIL idle_writes got extra_we=%0d cnt=%h required 0/%h", total_we - we0, byte_count, cnt0);
        end
        $display("test_edge_timing done");
    endtask

    task automatic test_reload();
        @(negedge clk);
        dl_active = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (core_reset !== 1'b1 || load_done !== 1'b0 || byte_count !== 25'h0) begin
            failures++;
            $display("FAIL reload_entry got rst=%b done=%b cnt=%h required 1/0/0", core_reset, load_done, byte_count);
        end
        @(negedge clk);
        stream(int'(TOT), 0);
        dl_active = 1'b0;
        wait_run("reload");
        checks++;
        if (byte_count !== TOT || sb.size() != 0) begin
            failures++;
            $display("FAIL reload_count got %h pending=%0d required %h/0", byte_count, sb.size(), TOT);
        end
        $display("test_reload done");
    endtask

    task automatic test_async_reset();
        start_load();
        stream(25'h100, 0);
        dl_wr   = 1'b1;
        dl_addr = 25'h100;
        dl_data = 8'h3C;
        @(posedge clk);
        #2;
        reset_n   = 1'b0;
        dl_wr     = 1'b0;
        dl_active = 1'b0;
        #1;
        checks++;
        if ({rom_we, rom_addr, rom_data, core_reset, load_done, load_error, byte_count} !==
            {4'h0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0, 25'h0}) begin
            failures++;
            $display("FAIL async_reset got we=%b addr=%h data=%h rst=%b done=%b err=%b cnt=%h required 0/0/0/1/0/0/0",
                     rom_we, rom_addr, rom_data, core_reset, load_done, load_error, byte_count);
        end
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        start_load();
        stream(int'(TOT), 0);
        dl_active = 1'b0;
        wait_run("post_reset");
        checks++;
        if (byte_count !== TOT || load_error !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_load got cnt=%h err=%b required %h/0", byte_count, load_error, TOT);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_short_load();
        test_out_of_range();
        test_edge_timing();
        test_reload();
        test_async_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
